// File: rtl/mul_issue_pkg.sv
// Shared types for the multiply issue queue: FSM states and the queued request entry.
// Entry field widths follow the package defaults, so the top-level width parameters must match them.
package mul_issue_pkg;

    localparam int MUL_DATA_WIDTH = 32;
    localparam int MUL_TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [MUL_TAG_WIDTH-1:0]  tag;
        logic [MUL_DATA_WIDTH-1:0] multiplicand;
        logic [MUL_DATA_WIDTH-1:0] multiplier;
    } entry_t;

endpackage

// File: rtl/mul_issue_fifo.sv
// Synchronous request FIFO with extra-bit pointers for full/empty; push is ignored when full.
module mul_issue_fifo
    import mul_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   wdata,
    input  logic                     pop,
    output entry_t                   rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    entry_t       mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    assign count = wptr - rptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (wptr == rptr);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: resetting the pointers discards queued entries.
    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mul_issue_queue.sv
// Issue stage for the iterative multiplier: queues tagged operand pairs, issues one at a time,
// waits for completion under a watchdog, and returns the product (or a timeout error) with its tag.
module mul_issue_queue
    import mul_issue_pkg::*;
#(
    parameter int DATA_WIDTH     = MUL_DATA_WIDTH,
    parameter int TAG_WIDTH      = MUL_TAG_WIDTH,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_multiplicand,
    input  logic [DATA_WIDTH-1:0]     in_multiplier,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      mul_start,
    output logic [DATA_WIDTH-1:0]     mul_multiplicand,
    output logic [DATA_WIDTH-1:0]     mul_multiplier,
    input  logic [2*DATA_WIDTH-1:0]   mul_product,
    input  logic                      mul_complete,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   out_product,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      out_error,
    output logic [$clog2(DEPTH):0]    occupancy
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    state_t                  state, state_nx;
    entry_t                  push_entry, head;
    logic                    fifo_full, fifo_empty, pop, wd_expired;
    logic [WDW-1:0]          wd_cnt;
    logic [DATA_WIDTH-1:0]   op_a, op_b;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic                    err_q;

    assign push_entry = '{tag: in_tag, multiplicand: in_multiplicand, multiplier: in_multiplier};
    assign pop        = (state == IDLE) && !fifo_empty;
    assign wd_expired = (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    mul_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (in_valid),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mul_complete || wd_expired) state_nx = RESP;
            RESP:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            wd_cnt <= '0;
            op_a   <= '0;
            op_b   <= '0;
            tag_q  <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (pop) begin
                    op_a  <= head.multiplicand;
                    op_b  <= head.multiplier;
                    tag_q <= head.tag;
                end
                ISSUE: wd_cnt <= '0;
                // Completion takes priority over a watchdog expiry in the same cycle.
                WAIT: if (mul_complete) begin
                    prod_q <= mul_product;
                    err_q  <= 1'b0;
                end else if (wd_expired) begin
                    prod_q <= '0;
                    err_q  <= 1'b1;
                end else begin
                    wd_cnt <= wd_cnt + WDW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready         = !fifo_full;
    assign mul_start        = (state == ISSUE);
    assign out_valid        = (state == RESP);
    assign mul_multiplicand = op_a;
    assign mul_multiplier   = op_b;
    assign out_product      = prod_q;
    assign out_tag          = tag_q;
    assign out_error        = err_q;

endmodule

// File: tb/tb_mul_issue_queue.sv
// Self-checking bench for mul_issue_queue: request-level reference model plus a multiply stub.
module tb_mul_issue_queue;
    localparam int DW = 32, TW = 4, DEPTH = 4, TO = 16;
    localparam int NEVER = 99;

    logic            clock = 1'b0;
    logic            reset, in_valid, in_ready, mul_start, mul_complete;
    logic            out_valid, out_ready, out_error;
    logic [DW-1:0]   in_multiplicand, in_multiplier, mul_multiplicand, mul_multiplier;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*DW-1:0] mul_product, out_product;
    logic [$clog2(DEPTH):0] occupancy;

    always #5 clock = ~clock;

    mul_issue_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_multiplicand(in_multiplicand), .in_multiplier(in_multiplier), .in_tag(in_tag),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_product(mul_product), .mul_complete(mul_complete), .out_valid(out_valid),
        .out_ready(out_ready), .out_product(out_product), .out_tag(out_tag),
        .out_error(out_error), .occupancy(occupancy)
    );

    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [TW-1:0] tag; } req_t;
    typedef enum int { P_IDLE, P_ISSUE, P_WAIT, P_RESP } phase_t;

    // Reference model: queued requests, the request in flight, and its result.
    req_t            q[$];
    req_t            cur;
    phase_t          phase;
    int              waited;
    logic [2*DW-1:0] res_prod;
    logic            res_err;

    // Stub and stimulus controls.
    int   lat, lat_mode;
    bit   stray_en, chk_en;
    logic d_valid, d_ready, d_rst;
    logic [DW-1:0] d_a, d_b;
    logic [TW-1:0] d_tag;

    logic [2*DW-1:0] lg_prod[$];
    logic [TW-1:0]   lg_tag[$];
    logic            lg_err[$];

    int tests, fails, cyc, start_cyc, resp_cyc;
    bit prev_ov;

    function automatic logic [2*DW-1:0] mul64(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [2*DW-1:0] x, y;
        x = {{DW{1'b0}}, a};
        y = {{DW{1'b0}}, b};
        return x * y;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom % 8);
        if (r == 0) return NEVER;
        if (r == 1) return TO - 1;
        if (r == 2) return TO - 2;
        return int'($urandom % 5);
    endfunction

    // One clock cycle: compare outputs, run the multiply stub, drive inputs, advance the model.
    task automatic cycle();
        bit push;
        @(negedge clock);
        cyc++;
        if (chk_en) begin
            chk("in_ready", in_ready, q.size() != DEPTH);
            chk("occupancy", occupancy, q.size());
            chk("mul_start", mul_start, phase == P_ISSUE);
            chk("out_valid", out_valid, phase == P_RESP);
            chk("mul_multiplicand", mul_multiplicand, cur.a);
            chk("mul_multiplier", mul_multiplier, cur.b);
            if (phase == P_RESP) begin
                chk("out_product", out_product, res_prod);
                chk("out_tag", out_tag, cur.tag);
                chk("out_error", out_error, res_err);
            end
        end
        if (mul_start === 1'b1) start_cyc = cyc;
        if (out_valid === 1'b1 && !prev_ov) resp_cyc = cyc;
        prev_ov = (out_valid === 1'b1);

        mul_complete = 1'b0;
        mul_product  = {$urandom, $urandom};
        if (phase == P_WAIT && waited == lat) begin
            mul_complete = 1'b1;
            mul_product  = mul64(cur.a, cur.b);
        end else if (stray_en && phase != P_WAIT && ($urandom % 4) == 0) begin
            mul_complete = 1'b1;
        end

        if (phase == P_RESP && d_ready && !d_rst) begin
            lg_prod.push_back(out_product);
            lg_tag.push_back(out_tag);
            lg_err.push_back(out_error);
        end

        reset = d_rst; in_valid = d_valid; out_ready = d_ready;
        in_multiplicand = d_a; in_multiplier = d_b; in_tag = d_tag;

        if (d_rst) begin
            q.delete();
            phase = P_IDLE; cur = '{0, 0, 0};
            res_prod = '0; res_err = 1'b0; waited = 0;
        end else begin
            push = d_valid && (q.size() != DEPTH);
            case (phase)
                P_IDLE: if (q.size() > 0) begin
                    cur = q.pop_front();
                    phase = P_ISSUE;
                    if (lat_mode < 0) lat = pick_lat();
                end
                P_ISSUE: begin phase = P_WAIT; waited = 0; end
                P_WAIT: begin
                    if (mul_complete) begin
                        res_prod = mul_product; res_err = 1'b0; phase = P_RESP;
                    end else if (waited == TO - 1) begin
                        res_prod = '0; res_err = 1'b1; phase = P_RESP;
                    end else begin
                        waited++;
                    end
                end
                P_RESP: if (d_ready) phase = P_IDLE;
                default: phase = P_IDLE;
            endcase
            if (push) q.push_back('{d_a, d_b, d_tag});
        end
    endtask

    task automatic push1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
        d_valid = 1'b1; d_a = a; d_b = b; d_tag = t;
        cycle();
        d_valid = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (lg_prod.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("result_arrival", lg_prod.size(), n);
    endtask

    initial begin
        int pc, base;
        tests = 0; fails = 0; cyc = 0; start_cyc = -1; resp_cyc = -1; prev_ov = 0;
        d_rst = 1'b1; d_valid = 1'b0; d_ready = 1'b1; d_a = '0; d_b = '0; d_tag = '0;
        lat_mode = 0; lat = 3; stray_en = 0; chk_en = 0;
        phase = P_IDLE; cur = '{0, 0, 0}; res_prod = '0; res_err = 1'b0; waited = 0;

        // Reset state.
        cycle();
        chk_en = 1;
        cycle();
        d_rst = 1'b0;
        chk("rst_out_product", out_product, 64'd0);
        chk("rst_out_error", out_error, 1'b0);
        cycle();

        // Single request: 7*6, tag 3, start two cycles after the push.
        lat = 3;
        push1(32'd7, 32'd6, 4'd3);
        pc = cyc;
        wait_log(1, 40);
        chk("t1_start_latency", start_cyc - pc, 2);
        chk("t1_resp_latency", resp_cyc - start_cyc, 5);
        chk("t1_product", lg_prod[0], 64'd42);
        chk("t1_tag", lg_tag[0], 4'd3);
        chk("t1_error", lg_err[0], 1'b0);

        // Back-pressure: fill the FIFO behind an unanswered result, then drain in order.
        lat = 1; d_ready = 1'b0;
        base = lg_prod.size();
        for (int i = 0; i < 5; i++) push1(32'd100 + i, 32'd3, 4'(i));
        cycle(); cycle(); cycle();
        chk("bp_occupancy_full", occupancy, DEPTH);
        chk("bp_in_ready_low", in_ready, 1'b0);
        push1(32'd1, 32'd1, 4'd9);
        chk("bp_refused_push", occupancy, DEPTH);
        d_ready = 1'b1;
        wait_log(base + 5, 200);
        for (int i = 0; i < 5; i++) chk("bp_tag_order", lg_tag[base + i], 64'(i));
        chk("bp_product0", lg_prod[base], 64'd300);

        // Width extremes.
        base = lg_prod.size();
        push1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
        push1(32'd0, 32'd123, 4'd2);
        wait_log(base + 2, 100);
        chk("max_product", lg_prod[base], 64'hFFFF_FFFE_0000_0001);
        chk("zero_product", lg_prod[base + 1], 64'd0);

        // Timeout, then a normal request.
        base = lg_prod.size();
        lat = NEVER;
        push1(32'd5, 32'd5, 4'd5);
        wait_log(base + 1, 60);
        chk("to_error", lg_err[base], 1'b1);
        chk("to_product", lg_prod[base], 64'd0);
        chk("to_resp_latency", resp_cyc - start_cyc, 17);
        lat = 2;
        push1(32'd9, 32'd9, 4'd6);
        wait_log(base + 2, 60);
        chk("after_to_product", lg_prod[base + 1], 64'd81);
        chk("after_to_error", lg_err[base + 1], 1'b0);

        // Completion on the last watchdog cycle wins over the timeout.
        base = lg_prod.size();
        lat = TO - 1;
        push1(32'd11, 32'd13, 4'd7);
        wait_log(base + 1, 60);
        chk("last_cycle_error", lg_err[base], 1'b0);
        chk("last_cycle_product", lg_prod[base], 64'd143);
        chk("last_cycle_latency", resp_cyc - start_cyc, 17);

        // Reset during WAIT with two entries queued; stray completions afterwards are ignored.
        lat = NEVER;
        push1(32'd1, 32'd2, 4'd8);
        push1(32'd3, 32'd4, 4'd9);
        push1(32'd5, 32'd6, 4'd10);
        cycle(); cycle();
        chk("pre_rst_occupancy", occupancy, 2);
        d_rst = 1'b1;
        cycle();
        d_rst = 1'b0;
        cycle();
        chk("post_rst_occupancy", occupancy, 0);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_mul_start", mul_start, 1'b0);
        base = lg_prod.size();
        stray_en = 1;
        repeat (20) cycle();
        chk("stray_no_result", lg_prod.size(), base);

        // Randomized traffic against the model.
        lat_mode = -1;
        repeat (3000) begin
            d_valid = ($urandom % 2) == 0;
            case ($urandom % 4)
                0: begin d_a = '1; d_b = $urandom; end
                1: begin d_a = $urandom; d_b = '0; end
                default: begin d_a = $urandom; d_b = $urandom; end
            endcase
            d_tag = 4'($urandom);
            d_ready = ($urandom % 3) != 0;
            d_rst = ($urandom % 400) == 0;
            cycle();
        end
        d_valid = 1'b0; d_ready = 1'b1; d_rst = 1'b0;
        repeat (150) cycle();
        chk("drain_empty", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
